// File: rtl/acc_drain_if.sv
// Output stream of the accumulator drain: valid/ready word bus with end-of-sweep marker.
interface acc_drain_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/acc_drain.sv
// Accumulator drain: sweeps an address window, streams each word out through a small
// credit-controlled FIFO and optionally overwrites each word with zero once it is read.
module acc_drain #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  mode,
  acc_drain_if.master           m_if
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]         DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L    = (ADDR_WIDTH+1)'(1);
  localparam logic [PW-1:0]       PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued;
  logic                  r_clear;
  logic                  r_vld_p1;
  logic [ADDR_WIDTH-1:0] r_addr_p1;
  logic                  r_last_p1;
  logic [DATA_WIDTH-1:0] r_mem  [FIFO_DEPTH];
  logic                  r_lmem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic w_credit;
  logic w_rd_en;
  logic w_last_issue;
  logic w_push;
  logic w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A read is only issued if its word is guaranteed a FIFO slot: buffered + in flight < depth.
  assign w_credit     = ({1'b0, r_count} + (CW+1)'(r_vld_p1)) < DEPTH_C;
  assign w_rd_en      = (r_state == S_RUN) && w_credit;
  assign w_last_issue = w_rd_en && ((r_issued + ONE_L) == r_len);
  assign w_push       = r_vld_p1;
  assign w_pop        = m_if.m_valid && m_if.m_ready;

  assign rd_en    = w_rd_en;
  assign rd_addr  = r_base + r_issued[ADDR_WIDTH-1:0];
  assign wr_en    = r_vld_p1 && r_clear;
  assign wr_we    = wr_en;
  assign wr_addr  = r_addr_p1;
  assign wr_wdata = '0;
  assign mode     = 1'b0;
  assign busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done     = (r_state == S_DONE);

  assign m_if.m_valid = (r_count != '0);
  assign m_if.m_data  = m_if.m_valid ? r_mem[r_rptr] : '0;
  assign m_if.m_last  = m_if.m_valid && r_lmem[r_rptr];

  // p0 -> p1: read issued this cycle, its data arrives on rd_rdata next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_issued  <= '0;
      r_clear   <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
      r_last_p1 <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_vld_p1 <= w_rd_en;
      if (w_rd_en) begin
        r_addr_p1 <= rd_addr;
        r_last_p1 <= w_last_issue;
        r_issued  <= r_issued + ONE_L;
      end
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base   <= base_addr;
            r_len    <= len;
            r_clear  <= clear_en;
            r_issued <= '0;
            r_state  <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN:   if (w_last_issue) r_state <= S_FLUSH;
        S_FLUSH: if (w_pop && m_if.m_last) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // p1 -> FIFO: capture the returning word together with its end-of-sweep flag
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr]  <= rd_rdata;
      r_lmem[r_wptr] <= r_last_p1;
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Randomized bench for acc_drain: RAM model, window/queue reference model and a per-cycle checker.
module tb_acc_drain;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int FD = 4;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          clear_en;
  logic          busy, done, rd_en, wr_en, wr_we, mode;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_rdata, wr_wdata;

  acc_drain_if #(.DATA_WIDTH(DW)) sif ();

  acc_drain #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .clear_en(clear_en), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_rdata(rd_rdata), .wr_en(wr_en), .wr_we(wr_we), .wr_addr(wr_addr),
    .wr_wdata(wr_wdata), .mode(mode), .m_if(sif.master)
  );

  logic [DW-1:0] ram  [512];
  logic [DW-1:0] gold [512];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] clr_q[$];
  logic [DW-1:0] log_data[$];
  logic [AW-1:0] log_rd[$];
  int            log_acc_cyc[$];

  int cyc, start_cyc, first_rd_cyc, exp_done_cyc, last_done_cyc;
  int n_rd, n_acc, n_clr, n_vec, n_err, ready_mode, tog;
  bit chk_en, seen_v, prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Accumulator RAM: registered read, overwrite on write
  initial forever begin
    @(posedge clk);
    if (rd_en === 1'b1) rd_rdata <= ram[rd_addr];
    else                rd_rdata <= {$urandom, $urandom};
    if (wr_en === 1'b1 && wr_we === 1'b1) ram[wr_addr] = wr_wdata;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       sif.m_ready = 1'b1;
      1:       sif.m_ready = ($urandom_range(0, 3) != 0);
      default: begin
        sif.m_ready = (tog == 0);
        tog = (tog + 1) % 3;
      end
    endcase
  end

  // Per-cycle checker against the reference queues
  initial begin
    logic [DW-1:0] d;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn || !chk_en) begin
        prev_stall = 1'b0;
        continue;
      end
      if (wr_en) begin
        if (clr_q.size() == 0) chk("clr_extra", 1, 0);
        else chk("clr_addr", wr_addr, clr_q.pop_front());
        chk("clr_after_rd", n_clr < n_rd, 1);
        chk("clr_wdata", wr_wdata, 0);
        n_clr++;
      end
      chk("we_mode", {wr_we, mode}, {wr_en, 1'b0});
      if (rd_en) begin
        if (exp_addr_q.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", rd_addr, exp_addr_q.pop_front());
        if (n_rd == 0) begin
          first_rd_cyc = cyc;
          chk("rd_lat", cyc - start_cyc, 1);
        end
        chk("credit", (n_rd - n_acc) < FD, 1);
        log_rd.push_back(rd_addr);
        n_rd++;
      end
      if (prev_stall)
        chk("stall_hold", {sif.m_valid, sif.m_last, sif.m_data}, {1'b1, prev_last, prev_data});
      if (sif.m_valid && !seen_v) begin
        seen_v = 1'b1;
        chk("mv_lat", cyc - first_rd_cyc, 2);
      end
      if (!sif.m_valid && sif.m_last) chk("last_no_valid", 1, 0);
      if (sif.m_valid && sif.m_ready) begin
        if (exp_q.size() == 0) chk("word_extra", 1, 0);
        else begin
          d = exp_q.pop_front();
          chk("m_data", sif.m_data, d);
          chk("m_last", sif.m_last, exp_q.size() == 0);
          if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
        end
        log_data.push_back(sif.m_data);
        log_acc_cyc.push_back(cyc - start_cyc);
        n_acc++;
      end
      if (done || cyc == exp_done_cyc) begin
        chk("done", done, cyc == exp_done_cyc);
        if (done) last_done_cyc = cyc - start_cyc;
      end
      prev_stall = sif.m_valid && !sif.m_ready;
      prev_data  = sif.m_data;
      prev_last  = sif.m_last;
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram[a]  = d;
    gold[a] = d;
  endtask

  task automatic run_start(input logic [AW-1:0] b, input logic [AW:0] l, input bit c);
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = b; len = l; clear_en = c;
    exp_q.delete(); exp_addr_q.delete(); clr_q.delete();
    log_data.delete(); log_rd.delete(); log_acc_cyc.delete();
    n_rd = 0; n_acc = 0; n_clr = 0; seen_v = 1'b0; last_done_cyc = -1;
    start_cyc = cyc;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      exp_q.push_back(gold[a]);
      exp_addr_q.push_back(a);
      if (c) begin
        clr_q.push_back(a);
        gold[a] = '0;
      end
    end
    if (l == 0) exp_done_cyc = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    len = (AW+1)'($urandom);
    clear_en = 1'($urandom);
    if (l != 0) chk("busy_run", busy, 1);
  endtask

  task automatic wait_end(input int maxc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy || cyc <= exp_done_cyc) && k < maxc) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= maxc) begin
      chk("timeout", 0, 1);
      exp_q.delete(); exp_addr_q.delete(); clr_q.delete();
    end
    chk("rd_left", exp_addr_q.size(), 0);
    chk("clr_left", clr_q.size(), 0);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required under 500000", cyc);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] t4 [4];
    logic [AW:0]   l;
    int k, bad;
    n_vec = 0; n_err = 0; tog = 0; ready_mode = 0;
    rstn = 1'b0; chk_en = 1'b0; start = 1'b0; base_addr = '0; len = '0; clear_en = 1'b0;
    sif.m_ready = 1'b1;
    exp_done_cyc = -10; start_cyc = 0; first_rd_cyc = 0; last_done_cyc = -1;
    for (int i = 0; i < 512; i++) poke(AW'(i), {$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {busy, done, rd_en, wr_en, wr_we, mode, sif.m_valid, sif.m_last}, 0);
    chk("rst_addr", {rd_addr, wr_addr}, 0);
    chk("rst_data", {sif.m_data, wr_wdata[31:0]}, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // T1: plain sweep of four known words
    for (int i = 0; i < 4; i++) poke(AW'(16 + i), DW'(i + 1));
    run_start(9'h010, 10'd4, 1'b0);
    wait_end(100);
    chk("t1_count", log_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", log_data[i], i + 1);
      chk("t1_acc_cyc", log_acc_cyc[i], i + 3);
      chk("t1_ram_kept", ram[16 + i], i + 1);
    end
    chk("t1_done_cyc", last_done_cyc, 7);

    // T2: same window with clear, then re-read must give zeros
    run_start(9'h010, 10'd4, 1'b1);
    wait_end(100);
    chk("t2_clears", n_clr, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_data", log_data[i], i + 1);
      chk("t2_ram_zero", ram[16 + i], 0);
    end
    run_start(9'h010, 10'd4, 1'b0);
    wait_end(100);
    for (int i = 0; i < 4; i++) chk("t2_reread", log_data[i], 0);

    // T3: backpressure 1,0,0 and a start while busy
    ready_mode = 2; tog = 0;
    run_start(9'h030, 10'd8, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 9'h000; len = 10'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_end(200);
    chk("t3_count", n_acc, 8);
    ready_mode = 0;

    // T4: window wraps past the top address
    run_start(9'h1FE, 10'd4, 1'b0);
    wait_end(100);
    t4[0] = 9'h1FE; t4[1] = 9'h1FF; t4[2] = 9'h000; t4[3] = 9'h001;
    for (int i = 0; i < 4; i++) chk("t4_rd_addr", log_rd[i], t4[i]);

    // T5: zero length, plus a start landing in the done cycle
    run_start(9'h020, 10'd0, 1'b0);
    start = 1'b1; base_addr = 9'h040; len = 10'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_end(50);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_reads", n_rd, 0);
    chk("t5_no_words", n_acc, 0);
    chk("t5_done_cyc", last_done_cyc, 1);

    // T6: reset mid-sweep, then a fresh sweep
    run_start(9'h080, 10'd16, 1'b0);
    k = 0;
    while (n_acc < 3 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) chk("t6_wait", 0, 1);
    #2;
    chk_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk("t6_rst_ctl", {busy, done, rd_en, wr_en, wr_we, mode, sif.m_valid, sif.m_last}, 0);
    chk("t6_rst_addr", {rd_addr, wr_addr}, 0);
    chk("t6_rst_data", sif.m_data, 0);
    exp_q.delete(); exp_addr_q.delete(); clr_q.delete();
    exp_done_cyc = -10;
    @(negedge clk);
    chk("t6_rst_hold", {busy, done, rd_en, sif.m_valid}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_quiet", {busy, rd_en, sif.m_valid}, 0);
    run_start(9'h080, 10'd16, 1'b0);
    wait_end(200);
    chk("t6_count", n_acc, 16);

    // Random sweeps
    for (int s = 0; s < 24; s++) begin
      ready_mode = $urandom_range(0, 2);
      l = ($urandom_range(0, 7) == 0) ? '0 : (AW+1)'($urandom_range(1, 40));
      run_start(AW'($urandom_range(0, 511)), l, 1'($urandom_range(0, 1)));
      wait_end(2000);
      chk("rnd_count", n_acc, l);
    end

    // Full-RAM sweeps: clear everything, then confirm it reads back as zero
    ready_mode = 1;
    run_start(9'h155, 10'd512, 1'b1);
    wait_end(5000);
    chk("full_count", n_acc, 512);
    ready_mode = 0;
    run_start(9'h000, 10'd512, 1'b0);
    wait_end(5000);
    bad = 0;
    for (int i = 0; i < 512; i++) if (log_data[i] !== '0) bad++;
    chk("full_zero", bad, 0);

    bad = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== gold[i]) bad++;
    chk("ram_image", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
